// File: rtl/dir_writeback.sv
// dir_writeback: gathers node directions eight at a time from the fabric,
// packs them into 32-bit words (one 4-bit nibble per node, top bit zero)
// and writes each word to memory through a level req/ack handshake.
// A full dump walks NODES nodes and raises int_done once at the end.
// NODES is expected to be a multiple of 8.
module dir_writeback #(
  parameter logic [31:0] BASE_ADDR = 32'h40002000,
  parameter int          NODES     = 1024
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        start,
  input  logic        abort,
  output logic [9:0]  node_idx,
  input  logic [2:0]  node_dir,
  output logic [31:0] addr_wr,
  output logic [31:0] data_wr,
  output logic        req_wr,
  input  logic        wr_ack,
  output logic        busy,
  output logic        int_done
);

  localparam int         WORDS     = NODES / 8;
  localparam logic [6:0] LAST_WORD = 7'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GATHER = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      state_q;
  logic [9:0]  node_cnt_q;
  logic [6:0]  word_cnt_q;
  logic [31:0] buf_q;
  logic [31:0] buf_d;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic        req_q;
  logic        done_q;

  // Word buffer with the current node's direction merged into its nibble;
  // used both to update the buffer and to load the complete word on nibble 7.
  always_comb begin
    buf_d = buf_q;
    buf_d[{node_cnt_q[2:0], 2'b00} +: 4] = {1'b0, node_dir};
  end

  // Dump sequencer: counters, word buffer and all registered outputs.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= IDLE;
      node_cnt_q <= '0;
      word_cnt_q <= '0;
      buf_q      <= '0;
      addr_q     <= BASE_ADDR;
      data_q     <= '0;
      req_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            node_cnt_q <= '0;
            word_cnt_q <= '0;
            state_q    <= GATHER;
          end
        end
        GATHER: begin
          if (abort) begin
            state_q <= IDLE;
          end else begin
            buf_q      <= buf_d;
            node_cnt_q <= node_cnt_q + 10'd1;
            if (node_cnt_q[2:0] == 3'd7) begin
              state_q <= WRITE;
              req_q   <= 1'b1;
              addr_q  <= BASE_ADDR + {23'd0, word_cnt_q, 2'b00};
              data_q  <= buf_d;
            end
          end
        end
        WRITE: begin
          // Abort wins over a coincident acknowledge: the word is dropped.
          if (abort) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
          end else if (wr_ack) begin
            req_q <= 1'b0;
            if (word_cnt_q == LAST_WORD) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              word_cnt_q <= word_cnt_q + 7'd1;
              state_q    <= GATHER;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign node_idx = node_cnt_q;
  assign addr_wr  = addr_q;
  assign data_wr  = data_q;
  assign req_wr   = req_q;
  assign int_done = done_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_dir_writeback.sv
// Directed testbench for dir_writeback: full dumps with a fabric model that
// derives node_dir from node_idx, delayed acknowledge, restart attempts,
// abort and asynchronous reset in the middle of a dump.
module tb_dir_writeback;

  localparam logic [31:0] BASE = 32'h40002000;

  logic        clk;
  logic        arst_n;
  logic        start;
  logic        abort;
  logic [9:0]  node_idx;
  logic [2:0]  node_dir;
  logic [31:0] addr_wr;
  logic [31:0] data_wr;
  logic        req_wr;
  logic        wr_ack;
  logic        busy;
  logic        int_done;

  int checks = 0;
  int errors = 0;
  int mode   = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] hold_addr_q[$];
  logic [31:0] hold_data_q[$];
  logic        hold_req_q[$];
  int          done_cnt;
  int          done_edge;
  int          first_req_edge;
  bit          timed_out;

  dir_writeback dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .start    (start),
    .abort    (abort),
    .node_idx (node_idx),
    .node_dir (node_dir),
    .addr_wr  (addr_wr),
    .data_wr  (data_wr),
    .req_wr   (req_wr),
    .wr_ack   (wr_ack),
    .busy     (busy),
    .int_done (int_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fabric model: mode 0 gives node_idx[2:0]; mode 1 gives 3'b101 on node 1023 only.
  always_comb begin
    node_dir = 3'b000;
    if (mode == 0) node_dir = node_idx[2:0];
    else if (node_idx == 10'd1023) node_dir = 3'b101;
  end

  // Runs one dump from a start pulse, acking every request (except the first
  // five cycles of delay_word), optionally pulsing start during gather of
  // restart_word and abort during the write of abort_word. Records traffic.
  task automatic run_dump(input int delay_word, input int restart_word, input int abort_word);
    int edges;
    int waitc;
    int word;
    bit restarted;
    bit aborted;
    edges = 0; waitc = 0; restarted = 0; aborted = 0;
    wr_addr_q.delete(); wr_data_q.delete();
    hold_addr_q.delete(); hold_data_q.delete(); hold_req_q.delete();
    done_cnt = 0; done_edge = -1; first_req_edge = -1; timed_out = 0;
    @(negedge clk);
    start = 1'b1; abort = 1'b0; wr_ack = 1'b1;
    forever begin
      @(negedge clk);
      edges++;
      start = 1'b0; abort = 1'b0; wr_ack = 1'b1;
      if (!busy && edges > 1) break;
      if (edges > 3000) begin timed_out = 1'b1; break; end
      if (int_done) begin done_cnt++; done_edge = edges; end
      if (req_wr && first_req_edge < 0) first_req_edge = edges;
      word = wr_addr_q.size();
      if (aborted) begin
        // waiting for idle
      end else if (req_wr && word == abort_word) begin
        abort = 1'b1; aborted = 1'b1;
      end else if (req_wr) begin
        if (word == delay_word && waitc < 5) begin
          wr_ack = 1'b0; waitc++;
          hold_req_q.push_back(req_wr);
          hold_addr_q.push_back(addr_wr);
          hold_data_q.push_back(data_wr);
        end else begin
          wr_addr_q.push_back(addr_wr);
          wr_data_q.push_back(data_wr);
        end
      end else if (word == restart_word && !restarted) begin
        start = 1'b1; restarted = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    arst_n = 1'b0; start = 1'b0; abort = 1'b0; wr_ack = 1'b0; mode = 0;
    @(negedge clk);
    checks++;
    if ({busy, req_wr, int_done} !== 3'b000 || node_idx !== 10'd0 || addr_wr !== BASE || data_wr !== 32'd0) begin
      errors++;
      $display("FAIL reset_values: busy=%b req=%b done=%b idx=%0d addr=%h data=%h, required 0 0 0 0 %h 0",
               busy, req_wr, int_done, node_idx, addr_wr, data_wr, BASE);
    end
    arst_n = 1'b1; wr_ack = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || req_wr !== 1'b0) begin
      errors++;
      $display("FAIL idle_wait: busy=%b req=%b, required 0 0", busy, req_wr);
    end
    $display("test_reset done");
  endtask

  task automatic test_full_dump();
    int bad;
    int first_bad;
    mode = 0;
    run_dump(-1, -1, -1);
    checks++;
    if (timed_out) begin errors++; $display("FAIL full_timeout: dump did not return to idle"); end
    checks++;
    if (wr_addr_q.size() != 128) begin
      errors++; $display("FAIL full_count: writes=%0d, required 128", wr_addr_q.size());
    end
    bad = 0; first_bad = -1;
    foreach (wr_addr_q[i]) begin
      if (wr_addr_q[i] !== BASE + 32'(4 * i) || wr_data_q[i] !== 32'h76543210) begin
        bad++; if (first_bad < 0) first_bad = i;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL full_words: %0d bad words, first %0d addr=%h data=%h, required addr=%h data=76543210",
               bad, first_bad, wr_addr_q[first_bad], wr_data_q[first_bad], BASE + 32'(4 * first_bad));
    end
    checks++;
    if (done_cnt != 1 || done_edge != 1153) begin
      errors++; $display("FAIL full_done: pulses=%0d at edge %0d, required 1 at edge 1153", done_cnt, done_edge);
    end
    checks++;
    if (first_req_edge != 9) begin
      errors++; $display("FAIL full_latency: first req at edge %0d, required 9", first_req_edge);
    end
    checks++;
    if (req_wr !== 1'b0 || addr_wr !== 32'h400021FC || data_wr !== 32'h76543210 || node_idx !== 10'd0) begin
      errors++;
      $display("FAIL full_hold: req=%b addr=%h data=%h idx=%0d, required 0 400021fc 76543210 0",
               req_wr, addr_wr, data_wr, node_idx);
    end
    $display("test_full_dump done: %0d writes", wr_addr_q.size());
  endtask

  task automatic test_wait_state();
    int bad;
    mode = 0;
    run_dump(3, -1, -1);
    checks++;
    if (hold_req_q.size() != 5) begin
      errors++; $display("FAIL wait_len: held cycles=%0d, required 5", hold_req_q.size());
    end
    bad = 0;
    foreach (hold_req_q[i])
      if (hold_req_q[i] !== 1'b1 || hold_addr_q[i] !== 32'h4000200C || hold_data_q[i] !== 32'h76543210) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL wait_stable: %0d unstable cycles, required 0 (req=1 addr=4000200c data=76543210)", bad);
    end
    checks++;
    if (wr_addr_q.size() != 128 || wr_addr_q[3] !== 32'h4000200C || wr_addr_q[4] !== 32'h40002010
        || wr_data_q[4] !== 32'h76543210) begin
      errors++;
      $display("FAIL wait_next: writes=%0d w3=%h w4=%h d4=%h, required 128 4000200c 40002010 76543210",
               wr_addr_q.size(), wr_addr_q[3], wr_addr_q[4], wr_data_q[4]);
    end
    checks++;
    if (done_cnt != 1 || done_edge != 1158) begin
      errors++; $display("FAIL wait_done: pulses=%0d at edge %0d, required 1 at edge 1158", done_cnt, done_edge);
    end
    $display("test_wait_state done");
  endtask

  task automatic test_last_node();
    int bad;
    mode = 1;
    run_dump(-1, -1, -1);
    bad = 0;
    for (int i = 0; i < 127; i++) if (wr_data_q[i] !== 32'd0) bad++;
    checks++;
    if (wr_data_q.size() != 128 || bad != 0) begin
      errors++; $display("FAIL last_zero: writes=%0d nonzero=%0d, required 128 0", wr_data_q.size(), bad);
    end
    checks++;
    if (wr_data_q[127] !== 32'h50000000 || wr_addr_q[127] !== 32'h400021FC) begin
      errors++;
      $display("FAIL last_word: addr=%h data=%h, required 400021fc 50000000", wr_addr_q[127], wr_data_q[127]);
    end
    mode = 0;
    $display("test_last_node done");
  endtask

  task automatic test_start_ignored();
    int bad;
    mode = 0;
    run_dump(-1, 10, -1);
    bad = 0;
    foreach (wr_addr_q[i]) if (wr_addr_q[i] !== BASE + 32'(4 * i)) bad++;
    checks++;
    if (wr_addr_q.size() != 128 || bad != 0 || done_cnt != 1 || done_edge != 1153) begin
      errors++;
      $display("FAIL restart_ignored: writes=%0d badaddr=%0d pulses=%0d edge=%0d, required 128 0 1 1153",
               wr_addr_q.size(), bad, done_cnt, done_edge);
    end
    $display("test_start_ignored done");
  endtask

  task automatic test_abort();
    mode = 0;
    run_dump(-1, -1, 20);
    checks++;
    if (req_wr !== 1'b0 || busy !== 1'b0 || done_cnt != 0 || wr_addr_q.size() != 20 || timed_out) begin
      errors++;
      $display("FAIL abort_stop: req=%b busy=%b pulses=%0d writes=%0d, required 0 0 0 20",
               req_wr, busy, done_cnt, wr_addr_q.size());
    end
    run_dump(-1, -1, -1);
    checks++;
    if (wr_addr_q.size() != 128 || wr_addr_q[0] !== BASE || wr_addr_q[127] !== 32'h400021FC || done_cnt != 1) begin
      errors++;
      $display("FAIL abort_restart: writes=%0d first=%h last=%h pulses=%0d, required 128 %h 400021fc 1",
               wr_addr_q.size(), wr_addr_q[0], wr_addr_q[127], done_cnt, BASE);
    end
    $display("test_abort done");
  endtask

  task automatic test_reset_mid_gather();
    bit saw_req;
    mode = 0;
    @(negedge clk);
    start = 1'b1; wr_ack = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (453) @(negedge clk);
    checks++;
    if (node_idx !== 10'd403 || busy !== 1'b1) begin
      errors++; $display("FAIL midreset_pos: idx=%0d busy=%b, required 403 1", node_idx, busy);
    end
    arst_n = 1'b0;
    #1;
    checks++;
    if ({busy, req_wr, int_done} !== 3'b000 || node_idx !== 10'd0 || addr_wr !== BASE || data_wr !== 32'd0) begin
      errors++;
      $display("FAIL midreset_async: busy=%b req=%b done=%b idx=%0d addr=%h data=%h, required 0 0 0 0 %h 0",
               busy, req_wr, int_done, node_idx, addr_wr, data_wr, BASE);
    end
    @(negedge clk);
    arst_n = 1'b1;
    saw_req = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (req_wr || busy) saw_req = 1'b1;
    end
    checks++;
    if (saw_req) begin
      errors++; $display("FAIL midreset_quiet: activity after reset=1, required 0");
    end
    $display("test_reset_mid_gather done");
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_wait_state();
    test_last_node();
    test_start_ignored();
    test_abort();
    test_reset_mid_gather();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
